// File: rtl/dense_mac_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : dense_mac_seq_if
// Purpose  : Handshake and operand/result bundle for the dense_mac_seq engine.
// Signals  : start, act_relu, x, w, b (requester -> engine)
//            busy, done, ovf, y        (engine -> requester)
// Modports : master = requester side, slave = engine side
// Revision : 1.0 - initial release
// ============================================================================
interface dense_mac_seq_if #(
  parameter int BITSIZE = 20,
  parameter int N_IN    = 6,
  parameter int N_OUT   = 2
);
  logic                          start;
  logic                          act_relu;
  logic [BITSIZE*N_IN-1:0]       x;
  logic [BITSIZE*N_IN*N_OUT-1:0] w;
  logic [BITSIZE*N_OUT-1:0]      b;
  logic                          busy;
  logic                          done;
  logic                          ovf;
  logic [BITSIZE*N_OUT-1:0]      y;

  modport master (
    output start, act_relu, x, w, b,
    input  busy, done, ovf, y
  );

  modport slave (
    input  start, act_relu, x, w, b,
    output busy, done, ovf, y
  );
endinterface
`default_nettype wire

// File: rtl/dense_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : dense_mac_seq
// Purpose  : Sequential dense layer, y[k] = act(b[k] + sum_i x[i]*w[k][i]),
//            one saturating fixed-point MAC per clock, shared multiplier.
// Ports    : clk   - clock, rising edge
//            reset - synchronous, active-low
//            bus   - dense_mac_seq_if.slave (start/act_relu/x/w/b in,
//                    busy/done/ovf/y out); interface widths must match the
//                    BITSIZE/N_IN/N_OUT parameters of this module.
// Revision : 1.0 - initial release
// ============================================================================
module dense_mac_seq #(
  parameter int BITSIZE = 20,
  parameter int FRAC    = 10,
  parameter int N_IN    = 6,
  parameter int N_OUT   = 2
) (
  input  wire logic       clk,
  input  wire logic       reset,
  dense_mac_seq_if.slave  bus
);

  localparam int c_IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int c_KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [0:0] c_S_IDLE = 1'b0;
  localparam logic [0:0] c_S_MAC  = 1'b1;

  localparam logic [c_IW-1:0] c_I_LAST = c_IW'(N_IN - 1);
  localparam logic [c_KW-1:0] c_K_LAST = c_KW'(N_OUT - 1);

  localparam logic [BITSIZE-1:0] c_MAX = {1'b0, {(BITSIZE-1){1'b1}}};
  localparam logic [BITSIZE-1:0] c_MIN = {1'b1, {(BITSIZE-1){1'b0}}};

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [0:0]                    r_state;
  logic [0:0]                    w_state_nxt;
  logic [c_IW-1:0]               r_i;
  logic [c_KW-1:0]               r_k;
  logic [BITSIZE-1:0]            r_acc;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_ovf;
  logic [BITSIZE-1:0]            r_y [N_OUT];

  // Operands captured on start so the requester may change inputs mid-run.
  logic [BITSIZE*N_IN-1:0]       r_x;
  logic [BITSIZE*N_IN*N_OUT-1:0] r_w;
  logic [BITSIZE*N_OUT-1:0]      r_b;
  logic                          r_relu;

  // --------------------------------------------------------------------------
  // Unpack captured operands into indexable arrays
  // --------------------------------------------------------------------------
  logic [BITSIZE-1:0] w_xa [N_IN];
  logic [BITSIZE-1:0] w_wa [N_OUT][N_IN];
  logic [BITSIZE-1:0] w_ba [N_OUT];

  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_x
      assign w_xa[gi] = r_x[gi*BITSIZE +: BITSIZE];
    end
    for (genvar gk = 0; gk < N_OUT; gk++) begin : g_kb
      assign w_ba[gk] = r_b[gk*BITSIZE +: BITSIZE];
      assign bus.y[gk*BITSIZE +: BITSIZE] = r_y[gk];
      for (genvar gj = 0; gj < N_IN; gj++) begin : g_w
        assign w_wa[gk][gj] = r_w[(gk*N_IN+gj)*BITSIZE +: BITSIZE];
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Saturating MAC datapath
  // --------------------------------------------------------------------------
  logic [BITSIZE-1:0]   w_xi;
  logic [BITSIZE-1:0]   w_wi;
  logic [2*BITSIZE-1:0] w_xe;
  logic [2*BITSIZE-1:0] w_we;
  logic [2*BITSIZE-1:0] w_prod;
  logic [2*BITSIZE-1:0] w_shift;
  logic                 w_p_ovf;
  logic [BITSIZE-1:0]   w_p;
  logic [BITSIZE:0]     w_sum;
  logic                 w_s_ovf;
  logic [BITSIZE-1:0]   w_s;
  logic [BITSIZE-1:0]   w_y_val;
  logic [c_KW-1:0]      w_k_nxt;

  assign w_xi    = w_xa[r_i];
  assign w_wi    = w_wa[r_k][r_i];
  assign w_xe    = {{BITSIZE{w_xi[BITSIZE-1]}}, w_xi};
  assign w_we    = {{BITSIZE{w_wi[BITSIZE-1]}}, w_wi};
  assign w_prod  = w_xe * w_we;
  // Arithmetic shift floors toward minus infinity.
  assign w_shift = $unsigned($signed(w_prod) >>> FRAC);

  // Shifted product fits only if its top BITSIZE+1 bits are a pure sign run.
  assign w_p_ovf = (w_shift[2*BITSIZE-1:BITSIZE-1] != {(BITSIZE+1){w_shift[2*BITSIZE-1]}});
  assign w_p     = w_p_ovf ? (w_shift[2*BITSIZE-1] ? c_MIN : c_MAX)
                           : w_shift[BITSIZE-1:0];

  assign w_sum   = {w_p[BITSIZE-1], w_p} + {r_acc[BITSIZE-1], r_acc};
  assign w_s_ovf = w_sum[BITSIZE] ^ w_sum[BITSIZE-1];
  assign w_s     = w_s_ovf ? (w_sum[BITSIZE] ? c_MIN : c_MAX)
                           : w_sum[BITSIZE-1:0];

  assign w_y_val = (r_relu && w_s[BITSIZE-1]) ? '0 : w_s;
  assign w_k_nxt = r_k + 1'b1;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: control decode (outputs of the controller)
  // --------------------------------------------------------------------------
  logic w_accept;
  logic w_mac;
  logic w_i_last;
  logic w_k_last;
  logic w_neuron_end;
  logic w_run_end;

  always_comb begin
    w_accept     = 1'b0;
    w_mac        = 1'b0;
    w_i_last     = (r_i == c_I_LAST);
    w_k_last     = (r_k == c_K_LAST);
    w_neuron_end = 1'b0;
    w_run_end    = 1'b0;
    case (r_state)
      c_S_IDLE: w_accept = bus.start;
      c_S_MAC: begin
        w_mac        = 1'b1;
        w_neuron_end = w_i_last;
        w_run_end    = w_i_last && w_k_last;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: if (bus.start) w_state_nxt = c_S_MAC;
      c_S_MAC:  if (w_run_end) w_state_nxt = c_S_IDLE;
      default:  w_state_nxt = c_S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath / status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_i    <= '0;
      r_k    <= '0;
      r_acc  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
      for (int k = 0; k < N_OUT; k++) r_y[k] <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_acc  <= bus.b[BITSIZE-1:0];
        r_i    <= '0;
        r_k    <= '0;
        r_ovf  <= 1'b0;
        r_busy <= 1'b1;
      end else if (w_mac) begin
        r_ovf <= r_ovf | w_p_ovf | w_s_ovf;
        if (!w_neuron_end) begin
          r_acc <= w_s;
          r_i   <= r_i + 1'b1;
        end else begin
          r_y[r_k] <= w_y_val;
          if (!w_run_end) begin
            r_k   <= w_k_nxt;
            r_i   <= '0;
            r_acc <= w_ba[w_k_nxt];
          end else begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
      end
    end
  end

  // Operand capture needs no reset: it is always reloaded before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_x    <= bus.x;
      r_w    <= bus.w;
      r_b    <= bus.b;
      r_relu <= bus.act_relu;
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dense_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dense_mac_seq
// Purpose  : Self-checking bench for dense_mac_seq (default parameters).
//            Table of directed vectors plus handshake / reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dense_mac_seq;

  localparam int BS    = 20;
  localparam int FR    = 10;
  localparam int NI    = 6;
  localparam int NO    = 2;

  logic clk;
  logic reset;

  dense_mac_seq_if #(.BITSIZE(BS), .N_IN(NI), .N_OUT(NO)) bus ();

  dense_mac_seq #(.BITSIZE(BS), .FRAC(FR), .N_IN(NI), .N_OUT(NO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [BS-1:0] xv;
    bit            ramp;   // x[i] = i * xv when set
    logic [BS-1:0] w0;
    logic [BS-1:0] w1;
    logic [BS-1:0] b0;
    logic [BS-1:0] b1;
    bit            relu;
    logic [BS-1:0] y0;
    logic [BS-1:0] y1;
    bit            ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_ops(input logic [BS-1:0] xv, input bit ramp,
                         input logic [BS-1:0] w0, input logic [BS-1:0] w1,
                         input logic [BS-1:0] b0, input logic [BS-1:0] b1);
    logic [BS-1:0] xe;
    for (int i = 0; i < NI; i++) begin
      xe = ramp ? BS'(xv * i) : xv;
      bus.x[i*BS +: BS] = xe;
      bus.w[(0*NI+i)*BS +: BS] = w0;
      bus.w[(1*NI+i)*BS +: BS] = w1;
    end
    bus.b[0 +: BS]  = b0;
    bus.b[BS +: BS] = b1;
  endtask

  task automatic issue_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 40 && !seen) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  seen;
    int  ndone;
    int  d1;
    int  d2;

    //                 xv       ramp w0       w1       b0       b1       relu y0       y1       ovf
    vecs[0] = '{20'h00400, 1'b0, 20'h00200, 20'h00200, 20'h00100, 20'h00100, 1'b0, 20'h00D00, 20'h00D00, 1'b0};
    vecs[1] = '{20'h00400, 1'b0, 20'hFFE00, 20'hFFE00, 20'h00100, 20'h00100, 1'b0, 20'hFF500, 20'hFF500, 1'b0};
    vecs[2] = '{20'h00400, 1'b0, 20'hFFE00, 20'hFFE00, 20'h00100, 20'h00100, 1'b1, 20'h00000, 20'h00000, 1'b0};
    vecs[3] = '{20'h7FFFF, 1'b0, 20'h7FFFF, 20'h7FFFF, 20'h00000, 20'h00000, 1'b0, 20'h7FFFF, 20'h7FFFF, 1'b1};
    vecs[4] = '{20'h00400, 1'b0, 20'h00200, 20'h00200, 20'h00100, 20'h00100, 1'b0, 20'h00D00, 20'h00D00, 1'b0};
    vecs[5] = '{20'h00400, 1'b1, 20'h00400, 20'h00200, 20'h00000, 20'h00100, 1'b0, 20'h03C00, 20'h01F00, 1'b0};
    vecs[6] = '{20'h00001, 1'b0, 20'hFFFFF, 20'hFFFFF, 20'h00000, 20'h00000, 1'b0, 20'hFFFFA, 20'hFFFFA, 1'b0};
    vecs[7] = '{20'h00400, 1'b0, 20'h80000, 20'h80000, 20'h00000, 20'h00000, 1'b0, 20'h80000, 20'h80000, 1'b1};
    vecs[8] = '{20'h00400, 1'b0, 20'h00200, 20'hFFE00, 20'h00100, 20'h00100, 1'b1, 20'h00D00, 20'h00000, 1'b0};

    // ---------------- reset with start held high ----------------
    reset        = 1'b0;
    bus.start    = 1'b1;
    bus.act_relu = 1'b0;
    set_ops(20'h00400, 1'b0, 20'h00200, 20'h00200, 20'h00100, 20'h00100);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_ovf",  {63'd0, bus.ovf},  64'd0);
    chk("rst_y",    {24'd0, bus.y},    64'd0);
    @(negedge clk);
    reset     = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_norun_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_norun_done", {63'd0, bus.done}, 64'd0);

    // ---------------- table-driven runs ----------------
    for (int v = 0; v < 9; v++) begin
      set_ops(vecs[v].xv, vecs[v].ramp, vecs[v].w0, vecs[v].w1, vecs[v].b0, vecs[v].b1);
      bus.act_relu = vecs[v].relu;
      issue_start();
      chk($sformatf("v%0d_busy_on", v), {63'd0, bus.busy}, 64'd1);
      wait_done(cyc, seen);
      chk($sformatf("v%0d_done_seen", v), {63'd0, seen}, 64'd1);
      chk($sformatf("v%0d_latency", v), 64'(cyc), 64'd12);
      chk($sformatf("v%0d_busy_off", v), {63'd0, bus.busy}, 64'd0);
      chk($sformatf("v%0d_y0", v), {44'd0, bus.y[0 +: BS]},  {44'd0, vecs[v].y0});
      chk($sformatf("v%0d_y1", v), {44'd0, bus.y[BS +: BS]}, {44'd0, vecs[v].y1});
      chk($sformatf("v%0d_ovf", v), {63'd0, bus.ovf}, {63'd0, vecs[v].ovf});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", v), {63'd0, bus.done}, 64'd0);
    end

    // ---------------- start ignored mid-run, inputs changed ----------------
    set_ops(20'h00400, 1'b0, 20'h00200, 20'h00200, 20'h00100, 20'h00100);
    bus.act_relu = 1'b0;
    issue_start();
    ndone = 0;
    d1    = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 3 || c == 7) begin
        bus.start = 1'b1;
        set_ops(20'h7FFFF, 1'b0, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        ndone++;
        d1 = c;
      end
    end
    bus.start = 1'b0;
    chk("hs_done_count", 64'(ndone), 64'd1);
    chk("hs_done_cycle", 64'(d1), 64'd12);
    chk("hs_y0", {44'd0, bus.y[0 +: BS]},  64'h00D00);
    chk("hs_y1", {44'd0, bus.y[BS +: BS]}, 64'h00D00);
    chk("hs_ovf", {63'd0, bus.ovf}, 64'd0);

    // ---------------- back-to-back with start held high ----------------
    set_ops(20'h00400, 1'b0, 20'h00200, 20'h00200, 20'h00100, 20'h00100);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    set_ops(20'h00400, 1'b0, 20'hFFE00, 20'hFFE00, 20'h00100, 20'h00100);
    d1 = 0;
    d2 = 0;
    for (int c = 1; c <= 40 && d2 == 0; c++) begin
      @(posedge clk);
      #1;
      if (c == 13) chk("b2b_busy_restart", {63'd0, bus.busy}, 64'd1);
      if (bus.done === 1'b1) begin
        if (d1 == 0) begin
          d1 = c;
          chk("b2b_first_y0", {44'd0, bus.y[0 +: BS]}, 64'h00D00);
        end else begin
          d2 = c;
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    chk("b2b_first_cycle", 64'(d1), 64'd12);
    chk("b2b_second_cycle", 64'(d2), 64'd25);
    chk("b2b_second_y0", {44'd0, bus.y[0 +: BS]},  64'hFF500);
    chk("b2b_second_y1", {44'd0, bus.y[BS +: BS]}, 64'hFF500);

    // ---------------- mid-run reset ----------------
    set_ops(20'h00400, 1'b0, 20'h00200, 20'h00200, 20'h00100, 20'h00100);
    repeat (2) @(posedge clk);
    issue_start();
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_busy", {63'd0, bus.busy}, 64'd0);
    chk("mr_y",    {24'd0, bus.y},    64'd0);
    chk("mr_ovf",  {63'd0, bus.ovf},  64'd0);
    @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) ndone++;
    end
    chk("mr_no_done", 64'(ndone), 64'd0);
    issue_start();
    wait_done(cyc, seen);
    chk("mr_fresh_seen", {63'd0, seen}, 64'd1);
    chk("mr_fresh_latency", 64'(cyc), 64'd12);
    chk("mr_fresh_y0", {44'd0, bus.y[0 +: BS]},  64'h00D00);
    chk("mr_fresh_y1", {44'd0, bus.y[BS +: BS]}, 64'h00D00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dense_mac_seq.md
# dense_mac_seq

Parametrised sequential dense-layer engine for the encoder datapath. It computes N_OUT fixed-point neurons y[k] = act(b[k] + Σ x[i]·w[k][i]) over N_IN inputs using one shared multiplier and one adder, one MAC per clock. The block adds a start/busy/done handshake, operand capture, saturating arithmetic, a sticky overflow flag and an optional ReLU. It replaces the fixed 1×6 encoder stage wherever a small fully-connected layer is needed.

## Interface
- BITSIZE, 20, signed two's-complement word width
- FRAC, 10, fractional bits (Q(BITSIZE-FRAC).FRAC)
- N_IN, 6, inputs per neuron (≥1)
- N_OUT, 2, neurons computed per run (≥1)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  request; accepted only in IDLE
- act_relu  in  1  activation select, sampled on start accept (1 = ReLU, 0 = identity)
- x  in  BITSIZE*N_IN  input vector; element i at [i*BITSIZE +: BITSIZE]
- w  in  BITSIZE*N_IN*N_OUT  weights; w[k][i] at [(k*N_IN+i)*BITSIZE +: BITSIZE]
- b  in  BITSIZE*N_OUT  biases; b[k] at [k*BITSIZE +: BITSIZE]
- busy  out  1  run in progress
- done  out  1  one-cycle pulse, all y valid
- ovf  out  1  sticky: saturation occurred during the current/last run
- y  out  BITSIZE*N_OUT  results; y[k] at [k*BITSIZE +: BITSIZE], registered

## Operation
- States: IDLE, MAC. Counters i (0..N_IN-1), k (0..N_OUT-1), widths $clog2 with minimum 1.
- IDLE, start=1: capture x, w, b, act_relu into internal registers; acc <= b[0]; i <= 0; k <= 0; ovf <= 0; busy <= 1; go to MAC. Inputs may change freely afterwards.
- MAC, each edge:
  - p = sat((x[i]*w[k][i]) >>> FRAC), full 2*BITSIZE signed product, arithmetic shift (floor).
  - s = sat(acc + p), computed at BITSIZE+1 bits.
  - Saturation clamps to [-2^(BITSIZE-1), 2^(BITSIZE-1)-1]. Any clamp in p or s sets ovf.
  - If i < N_IN-1: acc <= s; i <= i+1.
  - If i = N_IN-1: y[k] <= (relu && s<0) ? 0 : s.
    - If k < N_OUT-1: k <= k+1; i <= 0; acc <= b[k+1].
    - Else: done <= 1; busy <= 0; go to IDLE.
- start while in MAC (busy=1) is ignored and not queued.
- y[k] holds its last value until overwritten by a later run. Results from a run become visible neuron by neuron; consumers must use only done.
- reset=0 on any edge: state IDLE; busy, done, ovf, acc, counters and all y <= 0. An in-flight run is abandoned and done does not pulse. Reset dominates a simultaneous start.

## Timing
- Start accepted at edge E0; busy=1 from E0.
- y[k] written at edge E0+(k+1)*N_IN.
- done=1 and busy=0 during the cycle after edge E0+N_OUT*N_IN. Defaults give 12 cycles.
- done is high for exactly one cycle. start sampled in that same done cycle (state IDLE) is accepted, so runs can be issued back-to-back with no gap.
- ovf is valid with done and holds until the next accepted start or reset.

## Test plan
- Reset: hold reset=0 for 2 cycles with start=1 → busy=0, done=0, ovf=0, y=0, and no run begins after release.
- Basic (defaults, 1.0=0x00400): all x=0x00400, all w=0x00200, b=0x00100, relu=0 → done 12 cycles after start; y[0]=y[1]=0x00D00 (3.25); ovf=0.
- Sign/ReLU: same x, all w=0xFFE00 (-0.5), b=0x00100. relu=0 → y=0xFF500 (-2.75). relu=1 → y=0x00000. ovf=0 in both cases.
- Saturation: x=w=0x7FFFF, b=0 → y=0x7FFFF, ovf=1. A following run with basic stimulus → ovf=0.
- Handshake: pulse start again at cycles 3 and 7 of a run, and change x/w/b mid-run → single done at cycle 12 with results of the captured operands. Start held high through the done cycle → second run starts at once, next done 12 cycles later.
- Mid-run reset: assert reset=0 at cycle 5 of a run → y=0, busy=0, no done pulse. A fresh start then completes normally.
